ahb_sram_slave: RTL

- AHB slave with on-chip SRAM. It sits directly downstream of the processor's AHB master port through the bus interconnect and decoder.
- Serves core loads and stores with byte, halfword and word granularity.
- Wait-state count is programmable.
- Responds with a two-cycle ERROR to misaligned, oversized or out-of-range accesses.

---
 rtl/ahb_sram_slave.sv | 136 +++++++++++++
 1 files changed

// File: rtl/ahb_sram_slave.sv
`default_nettype none
// ============================================================================
// Module : ahb_sram_slave
// AHB slave over a word-wide SRAM with programmable wait states and a
// two-cycle ERROR response for misaligned, oversized or out-of-range accesses.
// Rev    : 1.0
// ============================================================================
module ahb_sram_slave #(
  parameter int          MEM_WORDS   = 1024,
  parameter int          WAIT_STATES = 0,
  parameter logic [31:0] BASE_MASK   = 32'h0000_FFFF
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [1:0]  HRESP,
  output logic [31:0] HRDATA
);

  localparam int          AW        = $clog2(MEM_WORDS);
  localparam logic [31:0] MEM_BYTES = 32'(MEM_WORDS * 4);
  localparam logic [2:0]  WAIT_LOAD = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_t;

  state_t        state, state_nxt;
  logic [AW+1:0] dp_addr;
  logic [2:0]    dp_size;
  logic          dp_write;
  logic [2:0]    wait_cnt;
  logic [31:0]   mem [MEM_WORDS];

  logic [31:0]   offset;
  logic          open_slot;
  logic          accept;
  logic          legal;
  logic [3:0]    lane_en;
  logic          unused_ok;

  assign unused_ok = ^{HBURST, HPROT, HTRANS[0]};
  assign offset    = HADDR & BASE_MASK;
  // A new address phase can only be taken while this slave is driving ready.
  assign open_slot = (state == S_IDLE) || (state == S_DATA) || (state == S_ERR2);
  assign accept    = open_slot && HSEL && HREADY && HTRANS[1];

  always_comb begin
    legal = (offset < MEM_BYTES);
    case (HSIZE)
      3'b000:  ;
      3'b001:  if (offset[0]) legal = 1'b0;
      3'b010:  if (offset[1:0] != 2'b00) legal = 1'b0;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    HREADYOUT = 1'b1;
    HRESP     = 2'b00;
    HRDATA    = 32'h0;
    case (state)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        if (wait_cnt == 3'd0) state_nxt = S_DATA;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 2'b01;
        state_nxt = S_ERR2;
      end
      default: begin
        if (state == S_ERR2) HRESP = 2'b01;
        if (state == S_DATA && !dp_write) HRDATA = mem[dp_addr[AW+1:2]];
        if (!accept)               state_nxt = S_IDLE;
        else if (!legal)           state_nxt = S_ERR1;
        else if (WAIT_STATES > 0)  state_nxt = S_WAIT;
        else                       state_nxt = S_DATA;
      end
    endcase
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state    <= S_IDLE;
      dp_addr  <= '0;
      dp_size  <= 3'b000;
      dp_write <= 1'b0;
      wait_cnt <= 3'd0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        dp_addr  <= offset[AW+1:0];
        dp_size  <= HSIZE;
        dp_write <= HWRITE;
      end
      if (state_nxt == S_WAIT && state != S_WAIT) wait_cnt <= WAIT_LOAD;
      else if (state == S_WAIT)                   wait_cnt <= wait_cnt - 3'd1;
    end
  end

  always_comb begin
    lane_en = 4'b0000;
    case (dp_size)
      3'b000:  lane_en[dp_addr[1:0]] = 1'b1;
      3'b001:  lane_en = dp_addr[1] ? 4'b1100 : 4'b0011;
      3'b010:  lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  end

  // SRAM array is deliberately left out of reset.
  always_ff @(posedge HCLK) begin
    if (state == S_DATA && dp_write) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[dp_addr[AW+1:2]][8*i +: 8] <= HWDATA[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire
